io_ctrl_hub: RTL and testbench

IO_CTRL_HUB -- requirements
Module: io_ctrl_hub

---
 rtl/io_ctrl_hub.sv | 145 ++++++++++++++
 tb/tb_io_ctrl_hub.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/io_ctrl_hub.sv
// IO pad control hub: Wishbone register file, per-pad output source muxing,
// input synchronisation with sticky rising-edge capture and a level interrupt.
module io_ctrl_hub #(
    parameter int NUM_PADS    = 38,
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [7:0]                   wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    input  logic [NUM_PADS-1:0]          io_in,
    output logic [NUM_PADS-1:0]          io_out,
    output logic [NUM_PADS-1:0]          io_oeb,
    input  logic [(NUM_SRC-1)*NUM_PADS-1:0] func_out,
    output logic [NUM_PADS-1:0]          io_in_sync,
    output logic                         irq
);

    localparam logic [63:0] PAD_MASK = (NUM_PADS >= 64) ? {64{1'b1}}
                                                         : ((64'd1 << NUM_PADS) - 64'd1);

    function automatic logic [255:0] sel_mask_f();
        logic [255:0] m;
        m = '0;
        for (int p = 0; p < 64; p++)
            if (p < NUM_PADS) m[4*p +: 4] = 4'hF;
        return m;
    endfunction

    localparam logic [255:0] SEL_MASK = sel_mask_f();

    logic                en_q;
    logic [63:0]         gpio_q, oeb_q, edge_q, mask_q;
    logic [255:0]        sel_q;
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] sync_prev;
    logic [SYNC_STAGES:0] valid_q;
    logic                ack_q, irq_q;
    logic                wr_en;
    logic [31:0]         rd_word, wr_val, wmask;
    logic [63:0]         in_w, rise_w, edge_clr;

    // The bus master must keep cyc/stb up through the ack cycle, otherwise the access is dropped.
    assign wbs_ack_o = ack_q & wbs_cyc_i & wbs_stb_i;
    assign wr_en     = wbs_ack_o & wbs_we_i;
    assign wbs_dat_o = wbs_ack_o ? rd_word : 32'd0;
    assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wr_val    = (rd_word & ~wmask) | (wbs_dat_i & wmask);

    assign io_in_sync = sync_q[SYNC_STAGES-1];
    assign in_w       = 64'(io_in_sync);
    // Edges are only trusted once sync_prev holds a genuinely sampled value.
    assign rise_w     = 64'(io_in_sync & ~sync_prev) & {64{valid_q[SYNC_STAGES]}};
    assign io_oeb     = en_q ? oeb_q[NUM_PADS-1:0] : {NUM_PADS{1'b1}};
    assign irq        = irq_q;

    always_comb begin
        rd_word = 32'd0;
        case (wbs_adr_i)
            8'h00: rd_word = {31'd0, en_q};
            8'h04: rd_word = gpio_q[31:0];
            8'h08: rd_word = gpio_q[63:32];
            8'h0C: rd_word = oeb_q[31:0];
            8'h10: rd_word = oeb_q[63:32];
            8'h14: rd_word = in_w[31:0];
            8'h18: rd_word = in_w[63:32];
            8'h1C: rd_word = edge_q[31:0];
            8'h20: rd_word = edge_q[63:32];
            8'h24: rd_word = mask_q[31:0];
            8'h28: rd_word = mask_q[63:32];
            8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h5C:
                rd_word = sel_q[{wbs_adr_i[4:2], 5'd0} +: 32];
            default: rd_word = 32'd0;
        endcase
    end

    always_comb begin
        edge_clr = 64'd0;
        if (wr_en && wbs_adr_i == 8'h1C) edge_clr[31:0]  = wbs_dat_i & wmask;
        if (wr_en && wbs_adr_i == 8'h20) edge_clr[63:32] = wbs_dat_i & wmask;
    end

    always_comb begin
        io_out = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (sel_q[4*p +: 4] == 4'd0) io_out[p] = gpio_q[p];
            for (int k = 1; k < NUM_SRC; k++)
                if (sel_q[4*p +: 4] == 4'(k)) io_out[p] = func_out[(k-1)*NUM_PADS + p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sync_prev <= '0;
            valid_q   <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_prev <= io_in_sync;
            valid_q   <= {valid_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A rising edge in the same cycle as its W1C clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            irq_q  <= 1'b0;
            en_q   <= 1'b0;
            gpio_q <= '0;
            oeb_q  <= PAD_MASK;
            edge_q <= '0;
            mask_q <= '0;
            sel_q  <= '0;
        end else begin
            ack_q  <= wbs_cyc_i & wbs_stb_i & ~ack_q;
            irq_q  <= en_q & (|(edge_q & mask_q));
            edge_q <= ((edge_q & ~edge_clr) | rise_w) & PAD_MASK;
            if (wr_en) begin
                case (wbs_adr_i)
                    8'h00: en_q           <= wr_val[0];
                    8'h04: gpio_q[31:0]   <= wr_val & PAD_MASK[31:0];
                    8'h08: gpio_q[63:32]  <= wr_val & PAD_MASK[63:32];
                    8'h0C: oeb_q[31:0]    <= wr_val & PAD_MASK[31:0];
                    8'h10: oeb_q[63:32]   <= wr_val & PAD_MASK[63:32];
                    8'h24: mask_q[31:0]   <= wr_val & PAD_MASK[31:0];
                    8'h28: mask_q[63:32]  <= wr_val & PAD_MASK[63:32];
                    8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h5C:
                        sel_q[{wbs_adr_i[4:2], 5'd0} +: 32] <=
                            wr_val & SEL_MASK[{wbs_adr_i[4:2], 5'd0} +: 32];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_ctrl_hub.sv
// Directed self-checking bench for io_ctrl_hub with hand-computed expectations.
module tb_io_ctrl_hub;

    localparam int NP = 38;
    localparam int NS = 4;
    localparam int SS = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [7:0]             wbs_adr_i;
    logic [31:0]            wbs_dat_i;
    logic                   wbs_ack_o;
    logic [31:0]            wbs_dat_o;
    logic [NP-1:0]          io_in, io_out, io_oeb, io_in_sync;
    logic [(NS-1)*NP-1:0]   func_out;
    logic                   irq;
    logic [31:0]            rd;

    int n_cmp = 0;
    int n_bad = 0;

    io_ctrl_hub #(.NUM_PADS(NP), .NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .func_out(func_out),
        .io_in_sync(io_in_sync), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts immediately; callers arrive here just after a rising edge.
    task automatic wb_cycle(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdata);
        int ack_cnt;
        int waitc;
        ack_cnt = 0;
        waitc   = 0;
        rdata   = 32'd0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        while (ack_cnt == 0 && waitc < 8) begin
            @(posedge clk); #1;
            waitc++;
            if (wbs_ack_o) begin
                ack_cnt++;
                rdata = wbs_dat_o;
            end
        end
        @(posedge clk); #1;
        if (wbs_ack_o) ack_cnt++;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        checkOutput("ack_once", 64'(ack_cnt), 64'd1);
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        @(posedge clk); #1;
        wb_cycle(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] d);
        @(posedge clk); #1;
        wb_cycle(1'b0, adr, 32'd0, 4'hF, d);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 8'h00; wbs_dat_i = 32'd0;
        io_in = '0;
        io_in[5] = 1'b1;
        func_out = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_oeb", io_oeb, 64'h3F_FFFF_FFFF);
        checkOutput("rst_out", io_out, 64'd0);
        checkOutput("rst_irq", irq, 64'd0);
        checkOutput("rst_ack", wbs_ack_o, 64'd0);
        checkOutput("rst_sync", io_in_sync, 64'd0);
        rst_n = 1'b1;
        wait_cycles(5);
        checkOutput("idle_dat", wbs_dat_o, 64'd0);
        checkOutput("sync_pass", io_in_sync, 64'h20);

        wb_read(8'h0C, rd); checkOutput("oeb_lo", rd, 64'hFFFF_FFFF);
        wb_read(8'h10, rd); checkOutput("oeb_hi", rd, 64'h3F);

        // Pad 5 was high across reset release: no edge may be recorded.
        wb_read(8'h1C, rd); checkOutput("no_edge_at_rst", rd, 64'd0);
        io_in[5] = 1'b0;
        wait_cycles(4);
        io_in[5] = 1'b1;
        wait_cycles(4);
        wb_read(8'h1C, rd); checkOutput("edge_pad5", rd, 64'h20);
        wb_write(8'h1C, 32'h20, 4'hF);
        wb_read(8'h1C, rd); checkOutput("edge_w1c", rd, 64'd0);

        wb_write(8'h40, 32'h0000_0002, 4'hF);
        wb_write(8'h0C, 32'hFFFF_FFFE, 4'hF);
        checkOutput("oeb_en0", io_oeb, 64'h3F_FFFF_FFFF);
        func_out[NP+0] = 1'b1;
        #1;
        checkOutput("src2_hi", io_out, 64'h1);
        wb_write(8'h00, 32'h1, 4'hF);
        checkOutput("oeb_en1", io_oeb, 64'h3F_FFFF_FFFE);
        wb_read(8'h00, rd); checkOutput("ctrl_rd", rd, 64'h1);
        func_out[NP+0] = 1'b0;
        #1;
        checkOutput("src2_lo", io_out, 64'd0);

        wb_write(8'h04, 32'hAABB_CCDD, 4'b0010);
        wb_read(8'h04, rd); checkOutput("gpio_sel", rd, 64'h0000_CC00);
        checkOutput("gpio_out", io_out, 64'h00_0000_CC00);
        wb_write(8'h08, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h08, rd); checkOutput("gpio_hi", rd, 64'h3F);
        checkOutput("gpio_out_hi", io_out, 64'h3F_0000_CC00);

        wb_write(8'h44, 32'h0000_0500, 4'hF);
        checkOutput("sel_oob", io_out, 64'h3F_0000_C800);
        func_out[2*NP+10] = 1'b1;
        wb_write(8'h44, 32'h0000_0300, 4'hF);
        checkOutput("sel_src3", io_out, 64'h3F_0000_CC00);

        wb_write(8'h50, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h50, rd); checkOutput("sel_w50", rd, 64'h00FF_FFFF);
        checkOutput("sel_hi_oob", io_out, 64'h00_0000_CC00);
        wb_write(8'h54, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h54, rd); checkOutput("sel_pad40", rd, 64'd0);
        wb_read(8'h30, rd); checkOutput("unmapped", rd, 64'd0);
        wb_read(8'h50, rd); checkOutput("sel_w50_kept", rd, 64'h00FF_FFFF);

        wb_write(8'h24, 32'h0000_1000, 4'hF);
        @(posedge clk); #1;
        io_in[12] = 1'b1;
        wait_cycles(3);
        checkOutput("irq_early", irq, 64'd0);
        wait_cycles(1);
        checkOutput("irq_rise", irq, 64'd1);
        wb_read(8'h1C, rd); checkOutput("edge_pad12", rd, 64'h1000);
        wb_write(8'h1C, 32'h1000, 4'hF);
        wait_cycles(1);
        checkOutput("irq_clr", irq, 64'd0);

        // Line up the W1C commit edge with the edge that latches a new rise.
        io_in[12] = 1'b0;
        wait_cycles(4);
        @(posedge clk); #1;
        io_in[12] = 1'b1;
        @(posedge clk); #1;
        wb_cycle(1'b1, 8'h1C, 32'h1000, 4'hF, rd);
        wb_read(8'h1C, rd); checkOutput("set_wins", rd, 64'h1000);
        checkOutput("irq_again", irq, 64'd1);

        wb_write(8'h00, 32'h0, 4'hF);
        wait_cycles(1);
        checkOutput("irq_en0", irq, 64'd0);
        checkOutput("oeb_dis", io_oeb, 64'h3F_FFFF_FFFF);
        io_in[13] = 1'b1;
        wait_cycles(4);
        wb_read(8'h1C, rd); checkOutput("edge_en0", rd, 64'h3000);
        wb_read(8'h14, rd); checkOutput("in_lo", rd, 64'h3020);
        io_in[33] = 1'b1;
        wait_cycles(4);
        wb_read(8'h18, rd); checkOutput("in_hi", rd, 64'h2);

        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 8'h04; wbs_dat_i = 32'hFFFF_FFFF; wbs_sel_i = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_out", io_out, 64'd0);
        checkOutput("async_irq", irq, 64'd0);
        @(posedge clk); #1;
        checkOutput("rst_drop_ack", wbs_ack_o, 64'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_read(8'h04, rd); checkOutput("rst_gpio", rd, 64'd0);
        wb_read(8'h0C, rd); checkOutput("rst_oeb_lo", rd, 64'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
